// File: rtl/demux_1to4_stream.sv
// -----------------------------------------------------------------------------
// demux_1to4_stream
//
// Registered 1-to-4 stream demultiplexer. A single valid/ready producer stream,
// tagged with a 2-bit destination index, is distributed to four independent
// valid/ready consumer channels. Each channel owns a single-entry holding
// register (its output register) and a wrapping count of accepted words.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_data    input word
//   in_sel     destination channel (0..3) for in_data
//   in_valid   producer has a word
//   in_ready   block accepts the word this cycle (combinational)
//   flush      synchronous clear of all channel valid bits
//   out_data   channel i data on bits [i*DATA_W +: DATA_W] (registered)
//   out_valid  channel i holds a word (registered)
//   out_ready  consumer i takes its word this cycle
//   cnt_sel    selects which channel counter is shown on cnt_value
//   cnt_value  words accepted for channel cnt_sel (combinational read)
// -----------------------------------------------------------------------------
module demux_1to4_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  input  logic [1:0]            cnt_sel,
  output logic [CNT_W-1:0]      cnt_value
);

  logic             sel_free_s;
  logic             accept_s;
  logic [3:0]       load_s;
  logic [3:0]       drain_s;
  logic [CNT_W-1:0] cnt_r [0:3];

  // Accept decode: readiness looks only at the selected channel, so a stalled
  // channel never blocks traffic headed elsewhere. A full channel that is
  // draining this cycle can take a new word (pass-through refill).
  always_comb begin
    sel_free_s = ~out_valid[in_sel] | out_ready[in_sel];
    in_ready   = ~rst & ~flush & sel_free_s;
    accept_s   = in_valid & ~rst & ~flush & sel_free_s;
    drain_s    = out_valid & out_ready;
    load_s     = 4'b0000;
    if (accept_s) begin
      load_s[in_sel] = 1'b1;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Counter readback mux.
  always_comb begin
    cnt_value = cnt_r[cnt_sel];
  end

  // Per-channel EMPTY/FULL holding registers; state is the out_valid bit.
  // Flush clears valid only; data registers keep their last contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 4'b0000;
      out_data  <= {(4*DATA_W){1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (flush) begin
          out_valid[i] <= 1'b0;
        end else if (load_s[i]) begin
          // Load wins over drain: the new word replaces the departing one.
          out_valid[i]                    <= 1'b1;
          out_data[i*DATA_W +: DATA_W]    <= in_data;
        end else if (drain_s[i]) begin
          out_valid[i] <= 1'b0;
        end else begin
          out_valid[i] <= out_valid[i];
        end
      end
    end
  end

  // Per-channel accepted-word counters; wrap silently, untouched by flush
  // and by drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      if (accept_s) begin
        cnt_r[in_sel] <= cnt_r[in_sel] + CNT_W'(1);
      end else begin
        cnt_r[in_sel] <= cnt_r[in_sel];
      end
    end
  end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_1to4_stream
//
// Directed self-checking bench for demux_1to4_stream. Inputs change shortly
// after the rising edge; registered outputs are sampled 1 time unit after the
// edge and combinational outputs after a short settle delay.
// -----------------------------------------------------------------------------
module tb_demux_1to4_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic                clk;
  logic                rst;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_sel;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [4*DATA_W-1:0] out_data;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [1:0]          cnt_sel;
  logic [CNT_W-1:0]    cnt_value;

  int checks;
  int errors;

  demux_1to4_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_sel   (cnt_sel),
    .cnt_value (cnt_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 4'b0000;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_cnt;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 4'b0000;
    in_sel = 2'd0; in_data = 8'h00; cnt_sel = 2'd0;
    repeat (2) tick();
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_hi got %b exp 0", in_ready); end
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b exp 0000", out_valid); end
    in_valid = 1'b0;
    rst = 1'b0;
    // Load ch1 and ch3 with no consumer ready.
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h5A;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_rel_in_ready got %b exp 1", in_ready); end
    tick();
    in_sel = 2'd3; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b1010) begin errors++; $display("FAIL preload_valid got %b exp 1010", out_valid); end
    checks++;
    if (out_data[15:8] !== 8'h5A || out_data[31:24] !== 8'hC3) begin
      errors++; $display("FAIL preload_data got %h exp c3xx5axx", out_data);
    end
    cnt_sel = 2'd1;
    #1;
    checks++;
    if (cnt_value !== 8'd1) begin errors++; $display("FAIL preload_cnt1 got %0d exp 1", cnt_value); end
    // Mid-cycle asynchronous reset.
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL async_rst_valid got %b exp 0000", out_valid); end
    checks++;
    if (out_data !== 32'h0000_0000) begin errors++; $display("FAIL async_rst_data got %h exp 0", out_data); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL async_rst_in_ready got %b exp 0", in_ready); end
    exp_cnt = 8'd0;
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #0.1;
      checks++;
      if (cnt_value !== exp_cnt) begin errors++; $display("FAIL async_rst_cnt%0d got %0d exp 0", s, cnt_value); end
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_routing();
    logic [7:0] exp_d;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_d    = 8'hA0 + 8'(k);
      in_valid = 1'b1; in_sel = 2'(k); in_data = exp_d;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready%0d got %b exp 1", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== (4'b0001 << k)) begin
        errors++; $display("FAIL route_valid%0d got %b exp %b", k, out_valid, 4'b0001 << k);
      end
      checks++;
      if (out_data[k*8 +: 8] !== exp_d) begin
        errors++; $display("FAIL route_data%0d got %h exp %h", k, out_data[k*8 +: 8], exp_d);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL route_drained got %b exp 0000", out_valid); end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #0.1;
      checks++;
      if (cnt_value !== 8'd1) begin errors++; $display("FAIL route_cnt%0d got %0d exp 1", s, cnt_value); end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 8'hB0 + 8'(k);
      tick();
    end
    checks++;
    if (out_valid !== 4'b1111) begin errors++; $display("FAIL flush_fill got %b exp 1111", out_valid); end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #0.1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL all_full_ready%0d got %b exp 0", s, in_ready); end
    end
    flush = 1'b1; out_ready = 4'b0001; in_sel = 2'd2; in_data = 8'hEE;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL flush_valid got %b exp 0000", out_valid); end
    checks++;
    if (out_data !== 32'hB3B2_B1B0) begin errors++; $display("FAIL flush_data_kept got %h exp b3b2b1b0", out_data); end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #0.1;
      checks++;
      if (cnt_value !== 8'd1) begin errors++; $display("FAIL flush_cnt%0d got %0d exp 1", s, cnt_value); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first got %b exp 1", in_ready); end
    tick();
    in_data = 8'h22;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_blocked got %b exp 0", in_ready); end
    tick();
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h11) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=11", out_valid[2], out_data[23:16]);
    end
    in_sel = 2'd0; in_data = 8'h33;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ch got %b exp 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0101 || out_data[7:0] !== 8'h33 || out_data[23:16] !== 8'h11) begin
      errors++; $display("FAIL bp_ch0_deliver got v=%b d=%h exp v=0101 d=xx11xx33", out_valid, out_data);
    end
    in_sel = 2'd2; in_data = 8'h22; out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h22) begin
      errors++; $display("FAIL bp_ch2_second got v=%b d=%h exp v=0100 d=22", out_valid, out_data[23:16]);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_empty got %b exp 0000", out_valid); end
    cnt_sel = 2'd2;
    #0.1;
    checks++;
    if (cnt_value !== 8'd3) begin errors++; $display("FAIL bp_cnt2 got %0d exp 3", cnt_value); end
    cnt_sel = 2'd0;
    #0.1;
    checks++;
    if (cnt_value !== 8'd2) begin errors++; $display("FAIL bp_cnt0 got %0d exp 2", cnt_value); end
  endtask

  task automatic test_passthrough();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hF0;
    tick();
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'hF0) begin
      errors++; $display("FAIL pt_preload got v=%b d=%h exp v=1 d=f0", out_valid[1], out_data[15:8]);
    end
    out_ready = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      in_data = 8'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL pt_ready%0d got %b exp 1", k, in_ready); end
      tick();
      checks++;
      if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'(k)) begin
        errors++; $display("FAIL pt_word%0d got v=%b d=%h exp v=1 d=%h", k, out_valid[1], out_data[15:8], 8'(k));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL pt_final_drain got %b exp 0", out_valid[1]); end
    cnt_sel = 2'd1;
    #0.1;
    checks++;
    if (cnt_value !== 8'd10) begin errors++; $display("FAIL pt_cnt1 got %0d exp 10", cnt_value); end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    out_ready = 4'b1000;
    cnt_sel   = 2'd3;
    in_valid  = 1'b1; in_sel = 2'd3;
    for (int k = 0; k < 257; k++) begin
      in_data = 8'(k);
      #0.1;
      if (k == 255) begin
        checks++;
        if (cnt_value !== 8'hFF) begin errors++; $display("FAIL wrap_allones got %h exp ff", cnt_value); end
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (cnt_value !== 8'd1) begin errors++; $display("FAIL wrap_cnt3 got %0d exp 1", cnt_value); end
    for (int s = 0; s < 3; s++) begin
      cnt_sel = 2'(s);
      #0.1;
      checks++;
      if (cnt_value !== 8'd0) begin errors++; $display("FAIL wrap_other%0d got %0d exp 0", s, cnt_value); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_routing();
    test_flush();
    test_backpressure();
    test_passthrough();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to4_stream.md
Name: demux_1to4_stream

Overview:
- Registered 1-to-4 stream demultiplexer, the distribution-side counterpart of the 4-to-1 select path.
- Takes one valid/ready input stream tagged with a 2-bit destination select and delivers each word to exactly one of four valid/ready output channels.
- Each channel has a single-entry holding register and a wrapping transfer counter.
- Sits between a single producer and four independent consumers.

Parameters:
- DATA_W, 8, width of a data word.
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  input word.
- in_sel  input  2  destination channel index (0..3) for in_data.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- flush  input  1  synchronous clear of all holding registers.
- out_data  output  4*DATA_W  channel i data on bits [i*DATA_W +: DATA_W].
- out_valid  output  4  channel i holds a word.
- out_ready  input  4  consumer i takes the word this cycle.
- cnt_sel  input  2  selects which channel counter is shown on cnt_value.
- cnt_value  output  CNT_W  words accepted for channel cnt_sel (combinational read).

Behaviour:
- Reset (rst=1, asynchronous):
  - out_valid=4'b0000, out_data all zero, all counters zero.
  - in_ready=0 while rst is high.
  - Reset mid-transfer discards held words without delivering them.
- Per-channel state machine (i=0..3), EMPTY/FULL, encoded as out_valid[i]:
  - EMPTY -> FULL on load (accept with in_sel=i).
  - FULL -> EMPTY on drain (out_valid[i] & out_ready[i]) with no load.
  - FULL -> FULL on drain plus load in the same cycle (pass-through refill). The new word replaces the old; no bubble.
  - FULL, no drain: out_data[i] and out_valid[i] are held stable.
- Decode and accept:
  - in_ready = ~rst & ~flush & (~out_valid[in_sel] | out_ready[in_sel]). Combinational.
  - in_ready depends only on the selected channel. A stalled channel never blocks a word destined for another channel.
  - Accept = in_valid & in_ready. On accept, channel in_sel loads in_data at the next edge. Latency is 1 cycle from accept to out_valid.
  - No other channel's data or valid changes on that load. Unselected out_data registers keep their last value.
  - Words are never duplicated or lost. Per-channel order equals the acceptance order.
- Flush:
  - flush=1 at an edge clears all out_valid bits; out_data keeps its value.
  - in_ready=0 during the flush cycle, so no accept occurs.
  - A drain in the same cycle as flush completes normally from the consumer's view.
  - Counters are not cleared by flush.
- Counters:
  - counter[in_sel] increments by 1 on each accept.
  - Wraps modulo 2^CNT_W: all-ones + 1 -> 0, with no saturation and no flag.
  - Counters do not change on drain.
  - cnt_value = counter[cnt_sel].
- Input protocol: the producer must hold in_data and in_sel stable while in_valid=1 and in_ready=0. The block does not check this.
- Boundary cases:
  - All four channels FULL with no out_ready: in_ready=0 for any in_sel.
  - in_valid=0: no state change other than drains.

Test Plan:
- Reset check: assert rst mid-clock with words loaded into ch1 and ch3 -> out_valid=0000 immediately, before the next edge; cnt_value=0 for all cnt_sel; in_ready=0 while rst=1.
- Basic routing: send 0xA0..0xA3 with in_sel=0,1,2,3 on consecutive cycles, out_ready=1111 -> each word appears on out_data[i] exactly 1 cycle after its accept, with out_valid one-hot per word; counters read 1,1,1,1.
- Backpressure isolation: out_ready[2]=0, then send 0x11 and 0x22 to ch2 and 0x33 to ch0:
  - 0x11 is accepted and held; in_ready=0 for the second ch2 word.
  - Retarget to in_sel=0: 0x33 is accepted and delivered.
  - Raise out_ready[2]: 0x22 is accepted in that same cycle.
  - ch2 delivers 0x11 then 0x22.
- Pass-through refill: with ch1 FULL, hold out_ready[1]=1 and in_valid=1 with in_sel=1 for 8 cycles with data 0..7 -> in_ready stays 1, out_valid[1] never deasserts, and ch1 delivers 0..7 in order.
- Counter wrap: CNT_W=8; accept 257 words on ch3 -> cnt_value (cnt_sel=3) reads 1; the other counters read 0.
- Flush: fill all four channels with no out_ready, then pulse flush for 1 cycle -> out_valid=0000 next cycle; in_ready=0 during the flush cycle; counters unchanged (1,1,1,1).
